mul_pipeline: RTL



---
 rtl/riscv_pkg.sv | 17 +
 rtl/mul_stage_reg.sv | 18 +
 rtl/mul_pipeline.sv | 80 ++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 opcode/funct constants and the multiplier stage record.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int REG_W = 5;
  localparam logic [6:0] OPCODE_ALU = 7'b0110011;
  localparam logic [6:0] MUL_FUNCT7 = 7'b0000001;
  localparam logic [2:0] F3_MUL = 3'b000;
  localparam logic [2:0] F3_MULH = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU = 3'b011;
  typedef struct packed {
    logic valid;
    logic [REG_W-1:0] rd;
    logic [2:0] funct3;
    logic [2*XLEN-1:0] product;
  } mul_stage_t;
endpackage

// File: rtl/mul_stage_reg.sv
// mul_stage_reg: one multiplier pipeline stage; flush kills the op, adv shifts it in.
module mul_stage_reg
  import riscv_pkg::*;
(
  input  logic       aclk,
  input  logic       arst,
  input  logic       i_adv,
  input  logic       i_flush,
  input  mul_stage_t i_d,
  output mul_stage_t o_q
);
  mul_stage_t r_q;
  always_ff @(posedge aclk or posedge arst)
    if (arst) r_q <= '0;
    else if (i_flush) r_q.valid <= 1'b0;
    else if (i_adv) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/mul_pipeline.sv
// mul_pipeline: STAGES-deep RV32M multiplier with stall, backpressure and flush.
// Define MUL_HIGH_EN to support MULH/MULHSU/MULHU; otherwise only the low product half.
module mul_pipeline
  import riscv_pkg::*;
#(
  parameter int WORD_SIZE = XLEN,
  parameter int STAGES = 5,
  parameter int RD_W = REG_W
) (
  input  logic                 aclk,
  input  logic                 arst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_op1,
  input  logic [WORD_SIZE-1:0] in_op2,
  input  logic [2:0]           in_funct3,
  input  logic [RD_W-1:0]      in_rd,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_result,
  output logic [RD_W-1:0]      out_rd,
  output logic                 busy,
  output logic [2**RD_W-1:0]   stage_rd_mask
);
  logic w_adv;
  logic [2*WORD_SIZE-1:0] w_prod;
  mul_stage_t w_d;
  mul_stage_t w_last;
  mul_stage_t w_q [STAGES];
  assign w_last = w_q[STAGES-1];
  assign w_adv = !w_last.valid || out_ready;
  assign in_ready = w_adv && !flush;
`ifdef MUL_HIGH_EN
  logic w_sx1, w_sx2, w_hi, w_unused;
  logic signed [WORD_SIZE:0] w_a, w_b;
  logic signed [2*WORD_SIZE+1:0] w_full;
  assign w_sx1 = in_funct3 == F3_MULH || in_funct3 == F3_MULHSU;
  assign w_sx2 = in_funct3 == F3_MULH;
  assign w_a = {w_sx1 && in_op1[WORD_SIZE-1], in_op1};
  assign w_b = {w_sx2 && in_op2[WORD_SIZE-1], in_op2};
  assign w_full = w_a * w_b;
  assign w_prod = w_full[2*WORD_SIZE-1:0];
  // funct3 1xx is never routed here; it falls through to the low half like MUL
  assign w_hi = w_last.funct3 == F3_MULH || w_last.funct3 == F3_MULHSU || w_last.funct3 == F3_MULHU;
  assign out_result = w_hi ? w_last.product[2*WORD_SIZE-1:WORD_SIZE] : w_last.product[WORD_SIZE-1:0];
  assign w_unused = ^w_full[2*WORD_SIZE+1:2*WORD_SIZE];
`else
  logic w_unused;
  assign w_prod = {{WORD_SIZE{1'b0}}, in_op1 * in_op2};
  assign out_result = w_last.product[WORD_SIZE-1:0];
  assign w_unused = ^{in_funct3, w_last.funct3, w_last.product[2*WORD_SIZE-1:WORD_SIZE]};
`endif
  always_comb begin
    w_d = '0;
    w_d.valid = in_valid && in_ready;
    w_d.rd = in_rd;
    w_d.product = w_prod;
`ifdef MUL_HIGH_EN
    w_d.funct3 = in_funct3;
`endif
  end
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      mul_stage_reg u_stage (.aclk, .arst, .i_adv(w_adv), .i_flush(flush), .i_d(w_d), .o_q(w_q[i]));
    end else begin : g_rest
      mul_stage_reg u_stage (.aclk, .arst, .i_adv(w_adv), .i_flush(flush), .i_d(w_q[i-1]), .o_q(w_q[i]));
    end
  end
  assign out_valid = w_last.valid;
  assign out_rd = w_last.rd;
  always_comb begin
    busy = 1'b0;
    stage_rd_mask = '0;
    for (int i = 0; i < STAGES; i++) begin
      busy = busy | w_q[i].valid;
      if (w_q[i].valid && w_q[i].rd != '0) stage_rd_mask[w_q[i].rd] = 1'b1;
    end
  end
endmodule
